// File: rtl/npu_vec_mac_act_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : npu_pkg
//  Purpose  : Shared types and constants for the NPU vector MAC/activation
//             engine: activation mode encoding, FSM state encoding, default
//             fixed-point constants and the dropout LFSR definition.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package npu_pkg;

    typedef enum logic [1:0] {
        ACT_ID    = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_HTANH = 2'd2,
        ACT_HSIG  = 2'd3
    } act_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_ACT   = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    localparam int C_FRAC_W = 8;
    localparam int C_ONE    = 1 << C_FRAC_W;
    localparam int C_HALF   = 1 << (C_FRAC_W - 1);

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] C_LFSR_TAPS = 16'hB400;
    localparam logic [15:0] C_LFSR_SEED = 16'hACE1;

    // Feedback bit shifted into the LSB on each LFSR step.
    function automatic logic lfsr_feedback(input logic [15:0] v);
        return ^(v & C_LFSR_TAPS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/npu_vec_mac_act_lane.sv
`default_nettype none
// ============================================================================
//  Module   : npu_act_lane
//  Purpose  : One lane of output post-processing. Purely combinational:
//             rescale accumulator, apply activation, saturate to DATA_W,
//             and force zero when the lane is dropped.
//  Ports    : acc    - signed lane accumulator (ACC_W)
//             mode   - activation select
//             drop   - lane dropped this vector
//             result - DATA_W signed result
//             sat    - scaled value was outside the DATA_W range
//  Revision : 1.0 - initial release
// ============================================================================
module npu_act_lane
    import npu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = C_FRAC_W,
    parameter int ACC_W  = 40
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  act_mode_t                mode,
    input  logic                     drop,
    output logic        [DATA_W-1:0] result,
    output logic                     sat
);

    localparam int c_s_w = ACC_W - FRAC_W;

    localparam logic signed [c_s_w-1:0] c_one     = c_s_w'(1) << FRAC_W;
    localparam logic signed [c_s_w-1:0] c_neg_one = -c_one;
    localparam logic signed [c_s_w-1:0] c_half    = c_s_w'(1) << (FRAC_W - 1);
    localparam logic signed [c_s_w-1:0] c_max     = (c_s_w'(1) << (DATA_W - 1)) - c_s_w'(1);
    localparam logic signed [c_s_w-1:0] c_min     = -(c_s_w'(1) << (DATA_W - 1));

    logic signed [c_s_w-1:0] w_s;
    logic signed [c_s_w-1:0] w_hsig;
    logic signed [c_s_w-1:0] w_act;
    logic signed [c_s_w-1:0] w_clip;

    always_comb begin
        // Arithmetic shift keeps the integer part; the cast just drops the
        // replicated sign bits, which ACC_W guarantees are redundant.
        w_s    = c_s_w'(acc >>> FRAC_W);
        w_hsig = (w_s >>> 2) + c_half;
        w_act  = w_s;

        case (mode)
            ACT_ID:    w_act = w_s;
            ACT_RELU:  w_act = (w_s < 0) ? '0 : w_s;
            ACT_HTANH: begin
                if (w_s > c_one)          w_act = c_one;
                else if (w_s < c_neg_one) w_act = c_neg_one;
                else                      w_act = w_s;
            end
            ACT_HSIG: begin
                if (w_hsig > c_one)  w_act = c_one;
                else if (w_hsig < 0) w_act = '0;
                else                 w_act = w_hsig;
            end
            default:   w_act = w_s;
        endcase

        if (w_act > c_max)      w_clip = c_max;
        else if (w_act < c_min) w_clip = c_min;
        else                    w_clip = w_act;

        // Saturation reports the pre-activation range, independent of drop.
        sat    = (w_s > c_max) || (w_s < c_min);
        result = drop ? '0 : DATA_W'(w_clip);
    end

endmodule
`default_nettype wire

// File: rtl/npu_vec_mac_act.sv
`default_nettype none
// ============================================================================
//  Module   : npu_vec_mac_act
//  Purpose  : Vectorised multiply-accumulate + activation engine. Accumulates
//             cfg_len beats of LANES signed products, then scales, activates,
//             saturates and optionally drops lanes, emitting one result
//             vector over a valid/ready handshake.
//  Ports    : clk, reset (async, active-high)
//             cfg_len/cfg_mode/cfg_drop_en/cfg_drop_thresh - latched on the
//                 first beat of a vector
//             in_valid/in_ready/in_a/in_b  - operand beat stream
//             out_valid/out_ready/out_data/out_sat - result vector stream
//             busy - engine not idle
//  Revision : 1.0 - initial release
// ============================================================================
module npu_vec_mac_act
    import npu_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter int          FRAC_W    = C_FRAC_W,
    parameter int          LANES     = 4,
    parameter int          LEN_W     = 8,
    parameter int          ACC_W     = 2*DATA_W + LEN_W,
    parameter logic [15:0] LFSR_SEED = C_LFSR_SEED
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic [1:0]              cfg_mode,
    input  logic                    cfg_drop_en,
    input  logic [7:0]              cfg_drop_thresh,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [LANES-1:0]        out_sat,
    output logic                    busy
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_in_fire;
    logic                    w_out_fire;
    logic [LEN_W-1:0]        w_len_eff;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        r_count;
    act_mode_t               r_mode;
    logic                    r_drop_en;
    logic [7:0]              r_drop_thresh;
    logic [15:0]             r_lfsr;
    logic [DATA_W-1:0]       w_lane_res [LANES];
    logic [LANES-1:0]        w_lane_sat;
    logic [LANES*DATA_W-1:0] r_out_data;
    logic [LANES-1:0]        r_out_sat;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_len_eff  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_in_fire)
                    w_state_next = (w_len_eff == LEN_W'(1)) ? ST_ACT : ST_ACCUM;
            end
            ST_ACCUM: begin
                // r_count holds beats already taken; this beat completes it.
                if (w_in_fire && (r_count + LEN_W'(1) >= r_len))
                    w_state_next = ST_ACT;
            end
            ST_ACT:  w_state_next = ST_EMIT;
            ST_EMIT: begin
                if (out_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            ST_IDLE:  begin in_ready = 1'b1; busy = 1'b0; end
            ST_ACCUM: in_ready  = 1'b1;
            ST_ACT:   in_ready  = 1'b0;
            ST_EMIT:  out_valid = 1'b1;
            default:  busy      = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Config latch, beat counter and dropout LFSR
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len         <= '0;
            r_count       <= '0;
            r_mode        <= ACT_ID;
            r_drop_en     <= 1'b0;
            r_drop_thresh <= '0;
            r_lfsr        <= LFSR_SEED;
        end else begin
            if (r_state == ST_IDLE && w_in_fire) begin
                r_len         <= w_len_eff;
                r_mode        <= act_mode_t'(cfg_mode);
                r_drop_en     <= cfg_drop_en;
                r_drop_thresh <= cfg_drop_thresh;
                r_count       <= LEN_W'(1);
            end else if (r_state == ST_ACCUM && w_in_fire) begin
                r_count <= r_count + LEN_W'(1);
            end

            // One step per emitted vector, only when that vector used dropout.
            if (w_out_fire && r_drop_en)
                r_lfsr <= {r_lfsr[14:0], lfsr_feedback(r_lfsr)};
        end
    end

    // ------------------------------------------------------------------
    // Per-lane accumulator, dropout decision and post-processing
    // ------------------------------------------------------------------
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        // Lane l looks at rotl(lfsr, 4*l)[7:0].
        localparam int c_rot = (4 * l) % 16;

        logic signed [2*DATA_W-1:0] w_prod;
        logic signed [ACC_W-1:0]    r_acc;
        logic [7:0]                 w_rand;
        logic                       w_drop;

        assign w_prod = $signed(in_a[l*DATA_W +: DATA_W]) * $signed(in_b[l*DATA_W +: DATA_W]);

        for (genvar k = 0; k < 8; k++) begin : g_rand_bit
            assign w_rand[k] = r_lfsr[(k + 16 - c_rot) % 16];
        end

        assign w_drop = r_drop_en && (w_rand < r_drop_thresh);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_acc <= '0;
            end else if (w_in_fire) begin
                // First beat of a vector overwrites; later beats add.
                if (r_state == ST_IDLE) r_acc <= ACC_W'(w_prod);
                else                    r_acc <= r_acc + ACC_W'(w_prod);
            end
        end

        npu_act_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W),
            .ACC_W  (ACC_W)
        ) u_act_lane (
            .acc    (r_acc),
            .mode   (r_mode),
            .drop   (w_drop),
            .result (w_lane_res[l]),
            .sat    (w_lane_sat[l])
        );
    end

    // ------------------------------------------------------------------
    // Result register: loaded in ACT, held through EMIT
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data <= '0;
            r_out_sat  <= '0;
        end else if (r_state == ST_ACT) begin
            for (int l = 0; l < LANES; l++)
                r_out_data[l*DATA_W +: DATA_W] <= w_lane_res[l];
            r_out_sat <= w_lane_sat;
        end
    end

    assign out_data = r_out_data;
    assign out_sat  = r_out_sat;

endmodule
`default_nettype wire
